debug_run_controller: RTL
=========================

Name: debug_run_controller

Overview:
- Run/step/halt sequencer for the 5-stage MIPS pipeline, driven by byte commands from the debug link.
- Gates the global pipeline enable (PC, IF/ID, ID/EX, EX/MEM, MEM/WB write).
- Arbitrates the register-file rs read port between the decode stage and a register-dump engine.
- The dump engine serialises all 32 GPRs as bytes onto a valid/ready TX stream.

Parameters:
- NB_DATA, 32, register width in bits; multiple of 8.
- N_REGS, 32, number of GPRs dumped.
- NB_ADDR, 5, register address width.
- NB_CMD, 8, command byte width.

Ports:
- clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_cmd_valid  input  1  command byte present.
- i_cmd  input  NB_CMD  command: 0x01 RUN, 0x02 STEP, 0x03 DUMP, 0x04 HALT; other values ignored.
- o_cmd_ready  output  1  command accepted on the edge where valid&ready.
- i_halt_instr  input  1  HALT opcode reached the pipeline end; single-cycle pulse.
- i_id_rs_addr  input  NB_ADDR  rs address from decode.
- o_rf_rs_addr  output  NB_ADDR  address driven to the register-file rs port.
- i_rf_rs_data  input  NB_DATA  register-file rs read data; combinational read.
- o_pipe_enable  output  1  global pipeline write enable.
- o_tx_valid  output  1  TX byte valid.
- o_tx_data  output  8  TX byte.
- i_tx_ready  input  1  TX sink ready.
- o_halted  output  1  high while in HALTED.

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_halted=0, o_cmd_ready=0 while asserted. Register index, byte counter and shift register all clear.
- States: IDLE, RUN, STEP, DUMP_READ, DUMP_SEND, HALTED.
- o_cmd_ready is 1 in IDLE, RUN and HALTED; 0 in STEP, DUMP_READ and DUMP_SEND.
- IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - DUMP → DUMP_READ with return=IDLE.
  - HALT and unknown commands are consumed, no effect.
- RUN:
  - o_pipe_enable=1 in every RUN cycle, starting the cycle after the accept edge.
  - i_halt_instr=1 or an accepted HALT command → HALTED; o_pipe_enable=0 from the next cycle.
  - Both on the same edge → single transition to HALTED.
  - Other commands in RUN are consumed, no effect.
- STEP:
  - Exactly one cycle with o_pipe_enable=1, then IDLE.
  - If i_halt_instr=1 in that cycle → HALTED instead.
- HALTED:
  - o_halted=1, o_pipe_enable=0.
  - DUMP → DUMP_READ with return=HALTED.
  - RUN, STEP, HALT and unknown commands are consumed and ignored.
  - Exit only via reset.
- o_rf_rs_addr: equals the register index in DUMP_READ and DUMP_SEND; otherwise equals i_id_rs_addr (combinational). o_pipe_enable=0 throughout the dump.
- DUMP_READ (1 cycle):
  - Capture i_rf_rs_data into the shift register.
  - Byte counter=0.
  - → DUMP_SEND.
- DUMP_SEND:
  - o_tx_valid=1; o_tx_data=current byte, LSB-first (byte 0 = bits 7:0).
  - o_tx_data is stable while valid&!ready.
  - On valid&ready: byte counter increments.
  - After byte NB_DATA/8−1 is accepted:
    - index==N_REGS−1 → index=0, o_tx_valid=0, go to the return state.
    - otherwise index+1 → DUMP_READ.
- Timing and ordering:
  - A full dump is N_REGS×(NB_DATA/8)=128 bytes, register 0 first.
  - Minimum duration is 32×5=160 cycles with ready tied high.
  - o_tx_valid never deasserts without a handshake, except on reset.
- Reset mid-dump or mid-run: immediate IDLE, o_tx_valid=0; a partial dump is abandoned.
- All state transitions occur on the rising clk edge; only reset is asynchronous.

Test Plan:
- Reset, then RUN; after 10 cycles pulse i_halt_instr → o_pipe_enable=1 from the cycle after accept until the cycle after the halt pulse, then 0; o_halted=1.
- STEP ×3 from IDLE → exactly three single-cycle o_pipe_enable pulses; o_cmd_ready=0 in each STEP cycle; end state IDLE.
- Preload register-file model with regN=0x0A0B0C00+N; DUMP with i_tx_ready=1 → 128 bytes: 00 0C 0B 0A, 01 0C 0B 0A … 1F 0C 0B 0A; o_rf_rs_addr walks 0..31; return to IDLE.
- DUMP with i_tx_ready toggling 1-in-3 cycles → same byte sequence; o_tx_data held stable while stalled; no byte duplicated or dropped.
- In RUN, HALT command and i_halt_instr on the same edge → one transition to HALTED; then RUN ignored (o_pipe_enable stays 0); then DUMP → returns to HALTED.
- Assert i_reset_n=0 during byte 2 of register 7 → o_tx_valid falls without waiting for a clock; state IDLE; a new DUMP restarts at register 0, byte 0.

Source files
------------

// File: rtl/debug_run_controller.sv
// rtl/debug_run_controller.sv - run/step/halt sequencer with a GPR dump engine on a byte stream
module debug_run_controller #(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_CMD  = 8
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic               i_cmd_valid,
  input  logic [NB_CMD-1:0]  i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt_instr,
  input  logic [NB_ADDR-1:0] i_id_rs_addr,
  output logic [NB_ADDR-1:0] o_rf_rs_addr,
  input  logic [NB_DATA-1:0] i_rf_rs_data,
  output logic               o_pipe_enable,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_ready,
  output logic               o_halted
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(N_REGS - 1);
  localparam logic [NB_CMD-1:0]  CMD_RUN   = NB_CMD'(1);
  localparam logic [NB_CMD-1:0]  CMD_STEP  = NB_CMD'(2);
  localparam logic [NB_CMD-1:0]  CMD_DUMP  = NB_CMD'(3);
  localparam logic [NB_CMD-1:0]  CMD_HALT  = NB_CMD'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_READ,
    ST_DUMP_SEND,
    ST_HALTED
  } state_t;

  state_t state, state_next;

  logic [NB_ADDR-1:0] reg_idx;
  logic [NB_BCNT-1:0] byte_cnt;
  logic [NB_DATA-1:0] shift_reg;
  logic               ret_halted;
  logic               cmd_ready;
  logic               dump_start;
  logic               tx_fire;
  logic               last_byte;
  logic               last_reg;

  assign tx_fire   = (state == ST_DUMP_SEND) && i_tx_ready;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (reg_idx == LAST_REG);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    dump_start    = 1'b0;
    o_pipe_enable = 1'b0;
    o_tx_valid    = 1'b0;
    o_halted      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (i_cmd == CMD_RUN) begin
            state_next = ST_RUN;
          end else if (i_cmd == CMD_STEP) begin
            state_next = ST_STEP;
          end else if (i_cmd == CMD_DUMP) begin
            state_next = ST_DUMP_READ;
            dump_start = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cmd_ready     = 1'b1;
        o_pipe_enable = 1'b1;
        // A halt opcode and a HALT command on the same edge collapse into one transition
        if (i_halt_instr || (i_cmd_valid && (i_cmd == CMD_HALT))) begin
          state_next = ST_HALTED;
        end
      end
      ST_STEP: begin
        o_pipe_enable = 1'b1;
        state_next    = i_halt_instr ? ST_HALTED : ST_IDLE;
      end
      ST_DUMP_READ: begin
        state_next = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready && last_byte) begin
          if (last_reg) begin
            state_next = ret_halted ? ST_HALTED : ST_IDLE;
          end else begin
            state_next = ST_DUMP_READ;
          end
        end
      end
      ST_HALTED: begin
        cmd_ready = 1'b1;
        o_halted  = 1'b1;
        if (i_cmd_valid && (i_cmd == CMD_DUMP)) begin
          state_next = ST_DUMP_READ;
          dump_start = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Ready is forced low during reset even though the held state is IDLE
  assign o_cmd_ready  = cmd_ready & i_reset_n;
  assign o_tx_data    = o_tx_valid ? shift_reg[7:0] : 8'h00;
  assign o_rf_rs_addr = ((state == ST_DUMP_READ) || (state == ST_DUMP_SEND)) ? reg_idx : i_id_rs_addr;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reg_idx    <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      ret_halted <= 1'b0;
    end else begin
      if (dump_start) begin
        ret_halted <= (state == ST_HALTED);
      end
      if (state == ST_DUMP_READ) begin
        shift_reg <= i_rf_rs_data;
        byte_cnt  <= '0;
      end else if (tx_fire) begin
        shift_reg <= shift_reg >> 8;
        byte_cnt  <= byte_cnt + NB_BCNT'(1);
        if (last_byte) begin
          reg_idx <= last_reg ? '0 : reg_idx + NB_ADDR'(1);
        end
      end
    end
  end

endmodule
